// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : Registered 16-bit integer ALU with 5-bit condition flags {C,L,F,Z,N}.
//            Optional macro ALU_CARRY_OPS_EN enables ADDC (06) and SUBC (0A).
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] R1,
    input  logic [15:0] R2,
    input  logic [7:0]  opcode,
    output logic [15:0] aluOut,
    output logic [4:0]  flags
);

    localparam logic [7:0] c_OP_AND  = 8'h01;
    localparam logic [7:0] c_OP_OR   = 8'h02;
    localparam logic [7:0] c_OP_XOR  = 8'h03;
    localparam logic [7:0] c_OP_ADD  = 8'h05;
    localparam logic [7:0] c_OP_LSH  = 8'h08;
    localparam logic [7:0] c_OP_SUB  = 8'h09;
    localparam logic [7:0] c_OP_CMP  = 8'h0B;
    localparam logic [7:0] c_OP_MOV  = 8'h0D;
    localparam logic [7:0] c_OP_ASHU = 8'h0F;
`ifdef ALU_CARRY_OPS_EN
    localparam logic [7:0] c_OP_ADDC = 8'h06;
    localparam logic [7:0] c_OP_SUBC = 8'h0A;
`endif

    localparam int c_FLAG_C = 4;
    localparam int c_FLAG_L = 3;
    localparam int c_FLAG_F = 2;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_N = 0;

    logic [15:0] r_result;
    logic [4:0]  r_flags;

    logic        w_cin;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_shift_big;
    logic [15:0] w_lsh;
    logic [15:0] w_ashu;
    logic        w_lt_unsigned;
    logic        w_lt_signed;
    logic [15:0] w_result;
    logic [4:0]  w_flags;

    // Carry-in is only honoured by the carry-chaining opcodes; plain ADD/SUB use zero.
    always_comb begin
        w_cin = 1'b0;
`ifdef ALU_CARRY_OPS_EN
        if ((opcode == c_OP_ADDC) || (opcode == c_OP_SUBC)) begin
            w_cin = r_flags[c_FLAG_C];
        end
`endif
    end

    // Shared adder/subtractor; bit 16 is carry-out for add and borrow for subtract.
    assign w_sum  = {1'b0, R1} + {1'b0, R2} + {16'd0, w_cin};
    assign w_diff = {1'b0, R2} - {1'b0, R1} - {16'd0, w_cin};

    assign w_add_ovf = (R1[15] == R2[15]) && (w_sum[15]  != R1[15]);
    assign w_sub_ovf = (R2[15] != R1[15]) && (w_diff[15] != R2[15]);

    // Shift amount is the whole 16-bit R1; anything 16 or above saturates.
    assign w_shift_big = |R1[15:4];
    assign w_lsh       = w_shift_big ? 16'd0 : (R2 << R1[3:0]);
    assign w_ashu      = w_shift_big ? {16{R2[15]}} : 16'($signed(R2) >>> R1[3:0]);

    // Compare is phrased as R1 > R2.
    assign w_lt_unsigned = (R2 < R1);
    assign w_lt_signed   = ($signed(R2) < $signed(R1));

    always_comb begin
        w_result = 16'd0;
        w_flags  = r_flags;
        case (opcode)
            c_OP_AND:  w_result = R1 & R2;
            c_OP_OR:   w_result = R1 | R2;
            c_OP_XOR:  w_result = R1 ^ R2;
            c_OP_MOV:  w_result = R1;
            c_OP_LSH:  w_result = w_lsh;
            c_OP_ASHU: w_result = w_ashu;
`ifdef ALU_CARRY_OPS_EN
            c_OP_ADD, c_OP_ADDC: begin
`else
            c_OP_ADD: begin
`endif
                w_result          = w_sum[15:0];
                w_flags[c_FLAG_C] = w_sum[16];
                w_flags[c_FLAG_F] = w_add_ovf;
                w_flags[c_FLAG_Z] = (w_sum[15:0] == 16'd0);
                w_flags[c_FLAG_N] = w_sum[15];
            end
`ifdef ALU_CARRY_OPS_EN
            c_OP_SUB, c_OP_SUBC: begin
`else
            c_OP_SUB: begin
`endif
                w_result          = w_diff[15:0];
                w_flags[c_FLAG_C] = w_diff[16];
                w_flags[c_FLAG_F] = w_sub_ovf;
                w_flags[c_FLAG_Z] = (w_diff[15:0] == 16'd0);
                w_flags[c_FLAG_N] = w_diff[15];
            end
            c_OP_CMP: begin
                w_result          = R2;
                w_flags[c_FLAG_Z] = (R1 == R2);
                w_flags[c_FLAG_L] = w_lt_unsigned;
                w_flags[c_FLAG_N] = w_lt_signed;
            end
            default: begin
                w_result = 16'd0;
                w_flags  = r_flags;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 16'd0;
            r_flags  <= 5'd0;
        end else begin
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    assign aluOut = r_result;
    assign flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] R1;
    logic [15:0] R2;
    logic [7:0]  opcode;
    logic [15:0] aluOut;
    logic [4:0]  flags;

    int tests;
    int fails;

    logic [15:0] m_out;
    logic [4:0]  m_flags;

`ifdef ALU_CARRY_OPS_EN
    localparam bit c_CARRY_OPS = 1'b1;
`else
    localparam bit c_CARRY_OPS = 1'b0;
`endif

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .R1     (R1),
        .R2     (R2),
        .opcode (opcode),
        .aluOut (aluOut),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {result, flags} computed with plain integer arithmetic.
    function automatic logic [20:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] op, input logic [4:0] f);
        int ua, ub, sa, sb, cin, r, s;
        logic [15:0] o;
        logic [4:0]  nf;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        o  = 16'd0;
        nf = f;
        cin = 0;
        case (op)
            8'h01: o = a & b;
            8'h02: o = a | b;
            8'h03: o = a ^ b;
            8'h0D: o = a;
            8'h08: begin
                r = (ua >= 16) ? 0 : (ub << ua);
                o = r[15:0];
            end
            8'h0F: begin
                r = (ua >= 16) ? (sb < 0 ? -1 : 0) : (sb >>> ua);
                o = r[15:0];
            end
            8'h05, 8'h06: begin
                if (op == 8'h06 && !c_CARRY_OPS) begin
                    o = 16'd0;
                end else begin
                    if (op == 8'h06) cin = int'(f[4]);
                    r = ua + ub + cin;
                    s = sa + sb + cin;
                    o = r[15:0];
                    nf[4] = (r > 65535);
                    nf[2] = (s > 32767) || (s < -32768);
                    nf[1] = (o == 16'd0);
                    nf[0] = o[15];
                end
            end
            8'h09, 8'h0A: begin
                if (op == 8'h0A && !c_CARRY_OPS) begin
                    o = 16'd0;
                end else begin
                    if (op == 8'h0A) cin = int'(f[4]);
                    r = ub - ua - cin;
                    s = sb - sa - cin;
                    o = r[15:0];
                    nf[4] = (r < 0);
                    nf[2] = (s > 32767) || (s < -32768);
                    nf[1] = (o == 16'd0);
                    nf[0] = o[15];
                end
            end
            8'h0B: begin
                o = b;
                nf[1] = (ua == ub);
                nf[3] = (ua > ub);
                nf[0] = (sa > sb);
            end
            default: o = 16'd0;
        endcase
        return {o, nf};
    endfunction

    // Applies one cycle of stimulus and advances the model; outputs are then sampled 1 ns after the edge.
    task automatic apply(input logic rs, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] op);
        logic [20:0] e;
        rst    = rs;
        R1     = a;
        R2     = b;
        opcode = op;
        @(posedge clk);
        #1;
        if (rs) begin
            m_out   = 16'd0;
            m_flags = 5'd0;
        end else begin
            e       = ref_op(a, b, op, m_flags);
            m_out   = e[20:5];
            m_flags = e[4:0];
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply(1'b1, 16'h0003, 16'h0004, 8'h05);
        tests++;
        if (aluOut !== 16'h0000) begin
            fails++; $display("FAIL reset_out: got %h want 0000", aluOut);
        end
        tests++;
        if (flags !== 5'b00000) begin
            fails++; $display("FAIL reset_flags: got %b want 00000", flags);
        end
    endtask

    task automatic test_add();
        apply(1'b0, 16'hFFFF, 16'h0001, 8'h05);
        tests++;
        if (aluOut !== 16'h0000 || flags !== 5'b10010) begin
            fails++; $display("FAIL add_carry: got %h/%b want 0000/10010", aluOut, flags);
        end
        apply(1'b0, 16'h7FFF, 16'h0001, 8'h05);
        tests++;
        if (aluOut !== 16'h8000 || flags !== 5'b00101) begin
            fails++; $display("FAIL add_ovf: got %h/%b want 8000/00101", aluOut, flags);
        end
    endtask

    task automatic test_logic();
        logic [7:0]  ops  [4];
        logic [15:0] want [4];
        ops  = '{8'h01, 8'h02, 8'h03, 8'h0D};
        want = '{16'h00F0, 16'h0FF0, 16'h0F00, 16'h00F0};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 16'h00F0, 16'h0FF0, ops[i]);
            tests++;
            if (aluOut !== want[i] || flags !== 5'b00101) begin
                fails++;
                $display("FAIL logic_op%h: got %h/%b want %h/00101", ops[i], aluOut, flags, want[i]);
            end
        end
    endtask

    task automatic test_shift();
        apply(1'b0, 16'h0003, 16'h8001, 8'h08);
        tests++;
        if (aluOut !== 16'h0008) begin
            fails++; $display("FAIL lsh3: got %h want 0008", aluOut);
        end
        apply(1'b0, 16'h0003, 16'h8001, 8'h0F);
        tests++;
        if (aluOut !== 16'hF000) begin
            fails++; $display("FAIL ashu3: got %h want F000", aluOut);
        end
        apply(1'b0, 16'hFFF9, 16'h8001, 8'h08);
        tests++;
        if (aluOut !== 16'h0000) begin
            fails++; $display("FAIL lsh_big: got %h want 0000", aluOut);
        end
        apply(1'b0, 16'hFFF9, 16'h8001, 8'h0F);
        tests++;
        if (aluOut !== 16'hFFFF || flags !== 5'b00101) begin
            fails++; $display("FAIL ashu_big: got %h/%b want FFFF/00101", aluOut, flags);
        end
        apply(1'b0, 16'h0010, 16'h7FFF, 8'h0F);
        tests++;
        if (aluOut !== 16'h0000) begin
            fails++; $display("FAIL ashu_16_pos: got %h want 0000", aluOut);
        end
    endtask

    task automatic test_cmp_sub();
        apply(1'b0, 16'h0005, 16'h0003, 8'h0B);
        tests++;
        if (aluOut !== 16'h0003 || flags[3] !== 1'b1 || flags[0] !== 1'b1 || flags[1] !== 1'b0) begin
            fails++; $display("FAIL cmp_gt: got %h/%b want 0003 L=1 N=1 Z=0", aluOut, flags);
        end
        tests++;
        if (flags !== 5'b01101) begin
            fails++; $display("FAIL cmp_gt_cf_hold: got %b want 01101", flags);
        end
        apply(1'b0, 16'h0003, 16'h0003, 8'h0B);
        tests++;
        if (flags[1] !== 1'b1 || flags[3] !== 1'b0) begin
            fails++; $display("FAIL cmp_eq: got %b want Z=1 L=0", flags);
        end
        apply(1'b0, 16'h0005, 16'h0003, 8'h09);
        tests++;
        if (aluOut !== 16'hFFFE || flags[4] !== 1'b1) begin
            fails++; $display("FAIL sub_borrow: got %h/%b want FFFE C=1", aluOut, flags);
        end
        apply(1'b0, 16'h0005, 16'h8003, 8'h0B);
        tests++;
        if (flags[3] !== 1'b0 || flags[0] !== 1'b1) begin
            fails++; $display("FAIL cmp_signed: got %b want L=0 N=1", flags);
        end
    endtask

    task automatic test_carry_chain();
        apply(1'b0, 16'hFFFF, 16'h0001, 8'h05);
        apply(1'b0, 16'h0000, 16'h0000, 8'h06);
        tests++;
`ifdef ALU_CARRY_OPS_EN
        if (aluOut !== 16'h0001 || flags[4] !== 1'b0) begin
            fails++; $display("FAIL addc_chain: got %h/%b want 0001 C=0", aluOut, flags);
        end
`else
        if (aluOut !== 16'h0000 || flags[4] !== 1'b1) begin
            fails++; $display("FAIL addc_disabled: got %h/%b want 0000 C=1", aluOut, flags);
        end
`endif
        apply(1'b0, 16'h1234, 16'h5678, 8'hA5);
        tests++;
        if (aluOut !== 16'h0000 || flags !== m_flags) begin
            fails++; $display("FAIL undef_op: got %h/%b want 0000/%b", aluOut, flags, m_flags);
        end
    endtask

    // Multi-word arithmetic issued back to back, checked against 64-bit arithmetic.
    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            logic [63:0] x, y, want;
            logic [63:0] got;
            bit sub;
            x   = {$urandom, $urandom};
            y   = {$urandom, $urandom};
            sub = n[0];
            got = 64'd0;
            for (int w = 0; w < 4; w++) begin
                logic [7:0] op;
                if (sub) op = (w == 0) ? 8'h09 : 8'h0A;
                else     op = (w == 0) ? 8'h05 : 8'h06;
                apply(1'b0, x[16*w +: 16], y[16*w +: 16], op);
                got[16*w +: 16] = aluOut;
            end
`ifdef ALU_CARRY_OPS_EN
            want = sub ? (y - x) : (x + y);
`else
            want = sub ? {48'd0, 16'(y[15:0] - x[15:0])} : {48'd0, 16'(x[15:0] + y[15:0])};
`endif
            tests++;
            if (got !== want) begin
                fails++; $display("FAIL chain64_%0d: got %h want %h", n, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ops [14];
        ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h08, 8'h09,
                8'h0A, 8'h0B, 8'h0D, 8'h0F, 8'h00, 8'h07, 8'hFF};
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            logic [7:0]  op;
            logic        rs;
            op = ops[$urandom_range(0, 13)];
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ((op == 8'h08 || op == 8'h0F) && $urandom_range(0, 3) != 0) a = 16'($urandom_range(0, 17));
            if ($urandom_range(0, 7) == 0) a = b;
            rs = ($urandom_range(0, 49) == 0);
            apply(rs, a, b, op);
            tests++;
            if (aluOut !== m_out || flags !== m_flags) begin
                fails++;
                $display("FAIL rand_%0d op=%h a=%h b=%h: got %h/%b want %h/%b",
                         i, op, a, b, aluOut, flags, m_out, m_flags);
            end
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        m_out   = 16'd0;
        m_flags = 5'd0;
        rst     = 1'b1;
        R1      = 16'd0;
        R2      = 16'd0;
        opcode  = 8'd0;
        @(negedge clk);
        test_reset();
        test_add();
        test_logic();
        test_shift();
        test_cmp_sub();
        test_carry_chain();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu.md
# alu

Registered 16-bit integer ALU for the CPU datapath. Each cycle it takes two register operands and an 8-bit opcode and registers a 16-bit result plus a 5-bit condition-flag vector. It covers add/subtract (with optional carry chaining), compare, bitwise logic, move and shifts. It sits between the register file read ports and the writeback mux; the flags feed the PSR/branch logic.

## Interface
- No parameters; datapath fixed at 16 bits, opcode at 8 bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- R1  input  16  source operand: shift amount for shifts, MOV source
- R2  input  16  destination operand: value shifted by shifts
- opcode  input  8  operation select
- aluOut  output  16  registered result
- flags  output  5  registered flags {C, L, F, Z, N}: [4]=C carry/borrow, [3]=L unsigned-greater, [2]=F signed overflow, [1]=Z zero/equal, [0]=N negative/signed-greater

## Operation
Opcodes, in hex:
- 01 AND: R1 & R2. Flags unchanged.
- 02 OR: R1 | R2. Flags unchanged.
- 03 XOR: R1 ^ R2. Flags unchanged.
- 05 ADD: R1 + R2 mod 2^16.
  - C = carry out of bit 15.
  - F = signed overflow.
  - Z = (result==0); N = result[15]; L unchanged.
- 06 ADDC: R1 + R2 + flags[4]. Flags as ADD.
- 09 SUB: R2 − R1 mod 2^16.
  - C = borrow (R1 > R2 unsigned).
  - F = signed overflow.
  - Z and N from result; L unchanged.
- 0A SUBC: R2 − R1 − flags[4]. Flags as SUB; borrow includes carry-in.
- 0B CMP: aluOut = R2.
  - Z = (R1==R2); L = R1 > R2 unsigned; N = R1 > R2 signed.
  - C and F unchanged.
- 0D MOV: aluOut = R1. Flags unchanged.
- 08 LSH: R2 << R1, zero fill. If R1 ≥ 16 (unsigned, whole 16 bits), result is 0. Flags unchanged.
- 0F ASHU: R2 arithmetic right shift by R1, sign fill. If R1 ≥ 16, result is 16 copies of R2[15]. Flags unchanged.
- Any other opcode: aluOut = 0, flags unchanged.

Other rules:
- "Unchanged" means the flag register holds its previous value.
- All arithmetic is unsigned 16-bit wraparound. Signed interpretation applies only to F, to N under CMP, and to ASHU fill.

## Timing
- Inputs are sampled on the rising edge of clk. aluOut and flags update on that same edge.
- Latency is 1 cycle; throughput is one operation per cycle. There is no handshake.
- Reset: when rst=1 at a rising edge, aluOut=0 and flags=0, regardless of opcode. Reset has priority over any operation.
- ADDC/SUBC take their carry-in from the flags register as it stands before the edge. Back-to-back ADDC operations chain correctly with no bubble.
- Flags are never combinationally dependent on the current inputs. Both outputs are pure register outputs.

## Configuration
- Macro ALU_CARRY_OPS_EN.
- Defined: ADDC (06) and SUBC (0A) are implemented as specified.
- Undefined: 06 and 0A behave as undefined opcodes (aluOut=0, flags unchanged). ADD and SUB still update C.

## Test plan
- Reset: rst=1 for one edge with opcode=05, R1=3, R2=4 -> aluOut=0000, flags=00000.
- ADD carry/overflow:
  - R1=FFFF, R2=0001, op 05 -> aluOut=0000, C=1, Z=1, F=0.
  - R1=7FFF, R2=0001 -> aluOut=8000, F=1, N=1, C=0.
- Logic/MOV: R1=00F0, R2=0FF0.
  - op 01 -> 00F0.
  - op 02 -> 0FF0.
  - op 03 -> 0F00.
  - op 0D -> 00F0.
  - Flags unchanged throughout.
- Shifts:
  - R1=0003, R2=8001, op 08 -> 0008.
  - Same inputs, op 0F -> F000.
  - R1=FFF9, op 08 -> 0000; op 0F with R2=8001 -> FFFF.
- Compare and SUB:
  - R1=0005, R2=0003, op 0B -> aluOut=0003, L=1, N=1, Z=0.
  - R1=0003, R2=0003, op 0B -> Z=1.
  - op 09 with R1=0005, R2=0003 -> aluOut=FFFE, C=1.
- Carry chain (ALU_CARRY_OPS_EN): op 05 R1=FFFF R2=0001 (C=1), next cycle op 06 R1=0000 R2=0000 -> aluOut=0001. Without the macro, the op 06 cycle gives aluOut=0000 and C stays 1.
